// File: rtl/ghost_pkg.sv
// Shared definitions for the ghost control slice: mode encodings, direction
// constants, the sequencer state type and the state/phase -> mode mapping.
package ghost_pkg;

  localparam logic [3:0] MODE_CHASE   = 4'b1000;
  localparam logic [3:0] MODE_SCATTER = 4'b0100;
  localparam logic [3:0] MODE_FRIGHT  = 4'b0010;
  localparam logic [3:0] MODE_EATEN   = 4'b0001;

  localparam logic [15:0] LEFT  = 16'h0100;
  localparam logic [15:0] RIGHT = 16'hFF00;
  localparam logic [15:0] UP    = 16'h00FF;
  localparam logic [15:0] DOWN  = 16'h0001;

  typedef enum logic [1:0] {
    ST_SCHED  = 2'd0,
    ST_FRIGHT = 2'd1,
    ST_EATEN  = 2'd2
  } ghost_state_e;

  // Odd schedule phases are Chase, even ones Scatter; overrides win.
  function automatic logic [3:0] state_mode(input ghost_state_e st,
                                            input logic [2:0]   phase);
    logic [3:0] m;
    case (st)
      ST_FRIGHT: m = MODE_FRIGHT;
      ST_EATEN:  m = MODE_EATEN;
      default:   m = phase[0] ? MODE_CHASE : MODE_SCATTER;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/move_pacer.sv
// Move pacer: counts game ticks and emits a registered one-cycle update
// strobe every period_i ticks; clear_i restarts the count and suppresses
// any strobe in that cycle.
module move_pacer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       clear_i,
  input  logic [7:0] period_i,
  output logic       update_o
);

  logic [7:0] move_cnt_q, move_cnt_d;
  logic       update_q, update_d;

  // Next count and strobe for this cycle.
  always_comb begin
    move_cnt_d = move_cnt_q;
    update_d   = 1'b0;
    if (clear_i) begin
      move_cnt_d = '0;
    end else if (tick_i) begin
      if (move_cnt_q == period_i - 8'd1) begin
        update_d   = 1'b1;
        move_cnt_d = '0;
      end else begin
        move_cnt_d = move_cnt_q + 8'd1;
      end
    end
  end

  // Counter and strobe registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      move_cnt_q <= '0;
      update_q   <= 1'b0;
    end else begin
      move_cnt_q <= move_cnt_d;
      update_q   <= update_d;
    end
  end

  assign update_o = update_q;

endmodule

// File: rtl/ghost_mode_sequencer.sv
// Ghost mode sequencer: scatter/chase schedule with frightened and eaten
// overrides, reversal request and per-mode move pacing for one ghost.
// Optional frightened-ending flash output: define GHOST_FRIGHT_FLASH_EN.
module ghost_mode_sequencer
  import ghost_pkg::*;
#(
  parameter int unsigned SCATTER_LONG       = 7,
  parameter int unsigned SCATTER_SHORT      = 5,
  parameter int unsigned CHASE_LEN          = 20,
  parameter int unsigned FRIGHT_LEN         = 6,
  parameter int unsigned MOVE_PERIOD        = 2,
  parameter int unsigned FRIGHT_MOVE_PERIOD = 3,
  parameter int unsigned EATEN_MOVE_PERIOD  = 1
`ifdef GHOST_FRIGHT_FLASH_EN
  ,
  parameter int unsigned FLASH_TICKS        = 2
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       power_pellet,
  input  logic       ghost_eaten,
  input  logic       ghost_home,
  output logic [3:0] mode,
  output logic       rotate,
  output logic       update,
  output logic       flash
);

  ghost_state_e state_q, state_d;
  logic [2:0]   phase_q, phase_d;
  logic [15:0]  sched_cnt_q, sched_cnt_d;
  logic [7:0]   fright_cnt_q, fright_cnt_d;
  logic         rotate_q, rotate_d;
  logic         rot_set;
  logic [15:0]  phase_len;
  logic [3:0]   mode_cur, mode_nxt;
  logic [7:0]   period;
  logic         mode_chg;
  logic         update_w;

  // State register: FSM state, schedule, fright timer and reversal flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_SCHED;
      phase_q      <= '0;
      sched_cnt_q  <= '0;
      fright_cnt_q <= '0;
      rotate_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      sched_cnt_q  <= sched_cnt_d;
      fright_cnt_q <= fright_cnt_d;
      rotate_q     <= rotate_d;
    end
  end

  // Next state: schedule advance, fright/eaten overrides, reversal set.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    sched_cnt_d  = sched_cnt_q;
    fright_cnt_d = fright_cnt_q;
    rot_set      = 1'b0;
    case (phase_q)
      3'd0, 3'd2: phase_len = 16'(SCATTER_LONG);
      3'd4, 3'd6: phase_len = 16'(SCATTER_SHORT);
      default:    phase_len = 16'(CHASE_LEN);
    endcase
    unique case (state_q)
      ST_SCHED: begin
        if (power_pellet) begin
          // Pellet beats a coincident phase boundary; schedule stays put.
          state_d      = ST_FRIGHT;
          fright_cnt_d = '0;
          rot_set      = 1'b1;
        end else if (tick) begin
          sched_cnt_d = sched_cnt_q + 16'd1;
          if (phase_q != 3'd7 && sched_cnt_q == phase_len - 16'd1) begin
            phase_d     = phase_q + 3'd1;
            sched_cnt_d = '0;
            rot_set     = 1'b1;
          end
        end
      end
      ST_FRIGHT: begin
        if (ghost_eaten) begin
          state_d = ST_EATEN;
        end else if (power_pellet) begin
          fright_cnt_d = '0;
        end else if (tick) begin
          if (fright_cnt_q == 8'(FRIGHT_LEN - 1)) begin
            state_d      = ST_SCHED;
            fright_cnt_d = '0;
          end else begin
            fright_cnt_d = fright_cnt_q + 8'd1;
          end
        end
      end
      ST_EATEN: begin
        if (ghost_home) state_d = ST_SCHED;
      end
      default: state_d = ST_SCHED;
    endcase
    rotate_d = rot_set | (rotate_q & ~update_w);
  end

  // Outputs: current/next mode and the move period of the current mode.
  always_comb begin
    mode_cur = state_mode(state_q, phase_q);
    mode_nxt = state_mode(state_d, phase_d);
    mode_chg = (mode_nxt != mode_cur);
    unique case (state_q)
      ST_FRIGHT: period = 8'(FRIGHT_MOVE_PERIOD);
      ST_EATEN:  period = 8'(EATEN_MOVE_PERIOD);
      default:   period = 8'(MOVE_PERIOD);
    endcase
  end

  move_pacer u_move_pacer (
    .clk_i    (clk),
    .rst_i    (reset),
    .tick_i   (tick),
    .clear_i  (mode_chg),
    .period_i (period),
    .update_o (update_w)
  );

  assign mode   = mode_cur;
  assign rotate = rotate_q;
  assign update = update_w;

`ifdef GHOST_FRIGHT_FLASH_EN
  logic flash_q, flash_d;

  // Flash toggles per tick in the last FLASH_TICKS of fright, else low.
  always_comb begin
    flash_d = flash_q;
    if (state_d != ST_FRIGHT || power_pellet) begin
      flash_d = 1'b0;
    end else if (tick && fright_cnt_d >= 8'(FRIGHT_LEN - FLASH_TICKS)) begin
      flash_d = ~flash_q;
    end
  end

  // Flash register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) flash_q <= 1'b0;
    else       flash_q <= flash_d;
  end

  assign flash = flash_q;
`else
  assign flash = 1'b0;
`endif

endmodule

// File: tb/tb_ghost_mode_sequencer.sv
// Self-checking bench for ghost_mode_sequencer: directed schedule/override
// scenarios plus randomized stimulus against a tick-level reference model.
module tb_ghost_mode_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       power_pellet;
  logic       ghost_eaten;
  logic       ghost_home;
  logic [3:0] mode;
  logic       rotate;
  logic       update;
  logic       flash;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  ghost_mode_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .power_pellet (power_pellet),
    .ghost_eaten  (ghost_eaten),
    .ghost_home   (ghost_home),
    .mode         (mode),
    .rotate       (rotate),
    .update       (update),
    .flash        (flash)
  );

  // Reference model: 0 = schedule, 1 = frightened, 2 = eaten.
  int m_state, m_phase, m_elapsed, m_fticks, m_moves;
  bit m_upd, m_rot, m_flash;
  int plen [8] = '{7, 20, 7, 20, 5, 20, 5, 0};

  function automatic logic [3:0] exp_mode(input int st, input int ph);
    if (st == 1) return 4'b0010;
    if (st == 2) return 4'b0001;
    return (ph % 2 == 1) ? 4'b1000 : 4'b0100;
  endfunction

  function automatic int move_period(input int st);
    if (st == 1) return 3;
    if (st == 2) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    m_state = 0; m_phase = 0; m_elapsed = 0; m_fticks = 0; m_moves = 0;
    m_upd = 0; m_rot = 0; m_flash = 0;
  endtask

  task automatic model_step(input bit tk, input bit pp, input bit ge, input bit gh);
    int ns, np, ne, nf;
    bit set_rot;
    ns = m_state; np = m_phase; ne = m_elapsed; nf = m_fticks; set_rot = 0;
    case (m_state)
      0: if (pp) begin
           ns = 1; nf = 0; set_rot = 1;
         end else if (tk && m_phase < 7) begin
           if (m_elapsed + 1 == plen[m_phase]) begin
             np = m_phase + 1; ne = 0; set_rot = 1;
           end else ne = m_elapsed + 1;
         end
      1: if (ge) ns = 2;
         else if (pp) nf = 0;
         else if (tk) begin
           if (m_fticks + 1 == 6) begin ns = 0; nf = 0; end
           else nf = m_fticks + 1;
         end
      default: if (gh) ns = 0;
    endcase
    m_rot = set_rot ? 1'b1 : (m_upd ? 1'b0 : m_rot);
    if (exp_mode(ns, np) != exp_mode(m_state, m_phase)) begin
      m_moves = 0; m_upd = 0;
    end else if (tk) begin
      if (m_moves + 1 == move_period(m_state)) begin m_moves = 0; m_upd = 1; end
      else begin m_moves = m_moves + 1; m_upd = 0; end
    end else m_upd = 0;
`ifdef GHOST_FRIGHT_FLASH_EN
    if (ns != 1 || pp) m_flash = 0;
    else if (tk && nf >= 6 - 2) m_flash = !m_flash;
`else
    m_flash = 0;
`endif
    m_state = ns; m_phase = np; m_elapsed = ne; m_fticks = nf;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("mode", 32'(mode), 32'(exp_mode(m_state, m_phase)));
    check_eq("rotate", 32'(rotate), 32'(m_rot));
    check_eq("update", 32'(update), 32'(m_upd));
    check_eq("flash", 32'(flash), 32'(m_flash));
  endtask

  // One clock cycle with the given inputs; called and returns at a negedge.
  task automatic cyc(input bit tk, input bit pp, input bit ge, input bit gh);
    tick = tk; power_pellet = pp; ghost_eaten = ge; ghost_home = gh;
    @(posedge clk);
    #1;
    model_step(tk, pp, ge, gh);
    @(negedge clk);
    tick = 0; power_pellet = 0; ghost_eaten = 0; ghost_home = 0;
    check_all();
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
    end
  endtask

  // Asserts reset at a negedge and checks its asynchronous effect.
  task automatic apply_reset();
    reset = 1;
    #1;
    check_eq("rst_mode", 32'(mode), 32'h4);
    check_eq("rst_update", 32'(update), 32'h0);
    check_eq("rst_rotate", 32'(rotate), 32'h0);
    check_eq("rst_flash", 32'(flash), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bit tk, pp, ge, gh;
    reset = 1; tick = 0; power_pellet = 0; ghost_eaten = 0; ghost_home = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    apply_reset();

    // Scatter to chase on tick 7, rotate held through the next update.
    do_ticks(6);
    check_eq("scatter_t6", 32'(mode), 32'h4);
    cyc(1, 0, 0, 0);
    check_eq("chase_t7", 32'(mode), 32'h8);
    check_eq("rot_t7", 32'(rotate), 32'h1);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check_eq("upd_t9", 32'(update), 32'h1);
    check_eq("rot_at_upd", 32'(rotate), 32'h1);
    cyc(0, 0, 0, 0);
    check_eq("rot_cleared", 32'(rotate), 32'h0);

    // Whole schedule, then permanent chase.
    apply_reset();
    do_ticks(84);
    check_eq("phase7_mode", 32'(mode), 32'h8);
    for (int i = 0; i < 100; i++) begin
      cyc(1, 0, 0, 0);
      check_eq("phase7_hold", 32'(mode), 32'h8);
    end
    cyc(0, 0, 0, 0);
    check_eq("phase7_norot", 32'(rotate), 32'h0);

    // Pellet at chase tick 3; chase resumes with 17 ticks left.
    apply_reset();
    do_ticks(10);
    check_eq("pre_pellet_rot", 32'(rotate), 32'h0);
    cyc(0, 1, 0, 0);
    check_eq("fright_mode", 32'(mode), 32'h2);
    check_eq("fright_rot", 32'(rotate), 32'h1);
    do_ticks(5);
    check_eq("fright_t5", 32'(mode), 32'h2);
    do_ticks(1);
    check_eq("fright_exit", 32'(mode), 32'h8);
    do_ticks(16);
    check_eq("chase_rem16", 32'(mode), 32'h8);
    do_ticks(1);
    check_eq("chase_rem17", 32'(mode), 32'h4);

    // Eaten on fright tick 2, pellet ignored while eaten, home returns.
    apply_reset();
    cyc(0, 1, 0, 0);
    do_ticks(2);
    cyc(0, 0, 1, 0);
    check_eq("eaten_mode", 32'(mode), 32'h1);
    do_ticks(3);
    cyc(0, 1, 0, 0);
    check_eq("eaten_pellet", 32'(mode), 32'h1);
    cyc(1, 0, 0, 0);
    check_eq("eaten_upd", 32'(update), 32'h1);
    cyc(0, 0, 0, 1);
    check_eq("home_mode", 32'(mode), 32'h4);

    // Pellet on the scatter->chase boundary tick.
    apply_reset();
    do_ticks(6);
    cyc(1, 1, 0, 0);
    check_eq("bound_pellet", 32'(mode), 32'h2);
    do_ticks(6);
    check_eq("bound_resume", 32'(mode), 32'h4);
    do_ticks(1);
    check_eq("bound_chase", 32'(mode), 32'h8);

    // Flash window at the end of fright.
    apply_reset();
    cyc(0, 1, 0, 0);
    check_eq("flash_f0", 32'(flash), 32'h0);
    for (int k = 1; k <= 6; k++) begin
      do_ticks(1);
`ifdef GHOST_FRIGHT_FLASH_EN
      check_eq("flash_seq", 32'(flash), (k == 4) ? 32'h1 : 32'h0);
`else
      check_eq("flash_off", 32'(flash), 32'h0);
`endif
    end

    // Reset while an update strobe is visible.
    apply_reset();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1, 0, 0, 0);
      if (update) found = 1;
    end
    check_eq("upd_found", 32'(found), 32'h1);
    apply_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tk = 1'($urandom_range(0, 1));
      pp = ($urandom_range(0, 39) == 0);
      ge = ($urandom_range(0, 5) == 0) && !pp;
      gh = ($urandom_range(0, 5) == 0);
      cyc(tk, pp, ge, gh);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
